register_file_ctrl: RTL and testbench

- Client-side controller for the 256x8 register file RAM: drives the RAM's address, write-enable and write-data pins, and consumes its registered read data.
- The register file has a 1-cycle read latency. The RAM is organised as 16 interrupt-level banks of 16 byte registers.
- Gives the CPU microsequencer one req/rsp handshake for byte and register-pair (16-bit) reads and writes, plus two bank operations: bank copy and bank clear.

---
 rtl/register_file_pkg.sv | 38 +++
 rtl/register_file_ctrl_if.sv | 35 +++
 rtl/register_file_ctrl.sv | 141 ++++++++++++++
 tb/tb_register_file_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared definitions for the register file controller.
//   op_t      : request opcodes carried on req_op
//   state_t   : controller FSM states (also exported on the debug port)
//   BANK_REGS : registers per interrupt-level bank
//   pair_reg  : register index of the high or low byte of a register pair
package register_file_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_COPY  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_A    = 4'd1,
    RD_B    = 4'd2,
    RD_WAIT = 4'd3,
    WR_A    = 4'd4,
    WR_B    = 4'd5,
    CLR     = 4'd6,
    COPY_RD = 4'd7,
    COPY_WR = 4'd8,
    RESP    = 4'd9
  } state_t;

  localparam int BANK_REGS = 16;

  // With hi_even set the high byte lives at the even register of the pair;
  // clearing it swaps the roles, so bit 0 is simply want_hi XOR hi_even.
  function automatic logic [3:0] pair_reg(input logic [3:0] r,
                                          input logic       want_hi,
                                          input logic       hi_even);
    return {r[3:1], want_hi ^ hi_even};
  endfunction

endpackage

// File: rtl/register_file_ctrl_if.sv
// Request/response bus between the CPU microsequencer and the register
// file controller.
//   req_valid/req_ready : request handshake
//   req_op, req_wide, req_level, req_reg, req_wdata : request fields
//   rsp_valid, rsp_rdata : one-cycle completion pulse and read data
//
// Handshake: a request transfers on a clock edge where req_valid and
// req_ready are both high. The master holds req_valid and all request
// fields stable until that edge and must not make req_valid depend on
// req_ready. rsp_valid is a single-cycle pulse with no back-pressure;
// rsp_rdata is meaningful only while rsp_valid is high.
interface register_file_ctrl_if;
  import register_file_pkg::*;

  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic        req_wide;
  logic [3:0]  req_level;
  logic [3:0]  req_reg;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  modport master (
    output req_valid, req_op, req_wide, req_level, req_reg, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_op, req_wide, req_level, req_reg, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/register_file_ctrl.sv
// Client-side controller for the 256x8 register file RAM (16 banks of 16
// byte registers, 1-cycle registered read). Serves byte and pair
// reads/writes plus whole-bank copy and clear, one request at a time.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : request/response interface (slave side)
//   ram_address, ram_write_en, ram_data_in : RAM control/write pins
//   ram_data_out   : RAM registered read data
//   state_dbg      : current FSM state, for observation only
module register_file_ctrl
  import register_file_pkg::*;
#(
  parameter logic [7:0] CLEAR_VALUE  = 8'h00,
  parameter bit         PAIR_HI_EVEN = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  register_file_ctrl_if.slave  bus,
  output logic [7:0]           ram_address,
  output logic                 ram_write_en,
  output logic [7:0]           ram_data_in,
  input  logic [7:0]           ram_data_out,
  output state_t               state_dbg
);

  state_t      state_q, state_d;
  logic        wide_q;
  logic [3:0]  level_q;
  logic [3:0]  reg_q;
  logic [15:0] wdata_q;
  logic [3:0]  idx_q;
  logic [15:0] rdata_q;

  logic [3:0]  hi_reg, lo_reg, first_reg;

  assign hi_reg    = pair_reg(reg_q, 1'b1, PAIR_HI_EVEN);
  assign lo_reg    = pair_reg(reg_q, 1'b0, PAIR_HI_EVEN);
  assign first_reg = wide_q ? hi_reg : reg_q;

  assign state_dbg     = state_q;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 16'h0000;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_READ:  state_d = RD_A;
            OP_WRITE: state_d = WR_A;
            OP_COPY:  state_d = COPY_RD;
            default:  state_d = CLR;
          endcase
        end
      end
      RD_A:    state_d = wide_q ? RD_B : RD_WAIT;
      RD_B:    state_d = RD_WAIT;
      RD_WAIT: state_d = RESP;
      WR_A:    state_d = wide_q ? WR_B : RESP;
      WR_B:    state_d = RESP;
      CLR:     state_d = (idx_q == 4'd15) ? RESP : CLR;
      COPY_RD: state_d = COPY_WR;
      COPY_WR: state_d = (idx_q == 4'd15) ? RESP : COPY_RD;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM pin decode. Everything depends on registered state only, except
  // the copy write data, which forwards the value the RAM read out for
  // the preceding COPY_RD cycle.
  always_comb begin
    ram_address  = 8'h00;
    ram_write_en = 1'b0;
    ram_data_in  = 8'h00;
    case (state_q)
      RD_A:    ram_address = {level_q, first_reg};
      RD_B:    ram_address = {level_q, lo_reg};
      WR_A: begin
        ram_address  = {level_q, first_reg};
        ram_write_en = 1'b1;
        ram_data_in  = wide_q ? wdata_q[15:8] : wdata_q[7:0];
      end
      WR_B: begin
        ram_address  = {level_q, lo_reg};
        ram_write_en = 1'b1;
        ram_data_in  = wdata_q[7:0];
      end
      CLR: begin
        ram_address  = {level_q, idx_q};
        ram_write_en = 1'b1;
        ram_data_in  = CLEAR_VALUE;
      end
      COPY_RD: ram_address = {level_q, idx_q};
      COPY_WR: begin
        ram_address  = {wdata_q[3:0], idx_q};
        ram_write_en = 1'b1;
        ram_data_in  = ram_data_out;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wide_q  <= 1'b0;
      level_q <= 4'h0;
      reg_q   <= 4'h0;
      wdata_q <= 16'h0000;
      idx_q   <= 4'h0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.req_valid) begin
        wide_q  <= bus.req_wide;
        level_q <= bus.req_level;
        reg_q   <= bus.req_reg;
        wdata_q <= bus.req_wdata;
        idx_q   <= 4'h0;
        rdata_q <= 16'h0000;
      end
      // The index wraps 15 -> 0 on the final bank cycle.
      if (state_q == CLR || state_q == COPY_WR) begin
        idx_q <= idx_q + 4'd1;
      end
      // RAM output lags the address by one cycle: in RD_B it holds the
      // high byte addressed in RD_A, in RD_WAIT the low (or only) byte.
      if (state_q == RD_B) begin
        rdata_q[15:8] <= ram_data_out;
      end
      if (state_q == RD_WAIT) begin
        rdata_q[7:0] <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_register_file_ctrl.sv
// Self-checking bench for register_file_ctrl with a behavioural 256x8
// registered-read RAM and an array reference model.
module tb_register_file_ctrl;
  import register_file_pkg::*;

  localparam logic [7:0] CLEAR_V = 8'h00;
  localparam bit         HI_EVEN = 1'b1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // ---------------- DUT and RAM ----------------
  register_file_ctrl_if bus();
  logic [7:0] ram_address, ram_data_in, ram_data_out;
  logic       ram_write_en;
  state_t     state_dbg;

  register_file_ctrl #(.CLEAR_VALUE(CLEAR_V), .PAIR_HI_EVEN(HI_EVEN)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .ram_address  (ram_address),
    .ram_write_en (ram_write_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .state_dbg    (state_dbg)
  );

  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (ram_write_en) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] pa_hi(input logic [3:0] lvl, input logic [3:0] r);
    logic [3:0] h;
    h = HI_EVEN ? (r & 4'hE) : (r | 4'h1);
    return {lvl, h};
  endfunction

  function automatic logic [7:0] pa_lo(input logic [3:0] lvl, input logic [3:0] r);
    return pa_hi(lvl, r) ^ 8'h01;
  endfunction

  // Monitor: pops one expectation per response pulse.
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h with nothing expected (cyc %0d)",
                   bus.rsp_rdata, cyc);
        end else begin
          logic [15:0] e;
          int lat, a, got_lat;
          e   = exp_q.pop_front();
          lat = lat_q.pop_front();
          a   = acc_q.pop_front();
          got_lat = cyc - a + 1;
          if (bus.rsp_rdata !== e) begin
            errors++;
            $display("FAIL rsp_rdata: got %h expected %h (cyc %0d)", bus.rsp_rdata, e, cyc);
          end
          checks++;
          if (got_lat != lat) begin
            errors++;
            $display("FAIL rsp_latency: got C%0d expected C%0d (cyc %0d)", got_lat, lat, cyc);
          end
        end
      end
      if (bus.req_ready) begin
        checks++;
        if (ram_write_en !== 1'b0) begin
          errors++;
          $display("FAIL idle_write_en: ram_write_en=%b while idle (cyc %0d)", ram_write_en, cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int op, input bit wide, input logic [3:0] lvl,
                       input logic [3:0] rg, input logic [15:0] wd,
                       input bit track, input int hold, output int acc);
    int waited;
    int lat;
    logic [15:0] e;
    logic [3:0] ii;
    acc = 0;
    @(negedge clock);
    bus.req_op    = op_t'(op[1:0]);
    bus.req_wide  = wide;
    bus.req_level = lvl;
    bus.req_reg   = rg;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    waited = 0;
    while (!bus.req_ready && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles", waited);
      bus.req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    e = 16'h0000;
    lat = 0;
    if (track) begin
      case (op)
        0: begin
          if (wide) begin
            e = {ref_mem[pa_hi(lvl, rg)], ref_mem[pa_lo(lvl, rg)]};
            lat = 4;
          end else begin
            e = {8'h00, ref_mem[{lvl, rg}]};
            lat = 3;
          end
        end
        1: begin
          if (wide) begin
            ref_mem[pa_hi(lvl, rg)] = wd[15:8];
            ref_mem[pa_lo(lvl, rg)] = wd[7:0];
            lat = 3;
          end else begin
            ref_mem[{lvl, rg}] = wd[7:0];
            lat = 2;
          end
        end
        2: begin
          for (int i = 0; i < BANK_REGS; i++) begin
            ii = i[3:0];
            ref_mem[{wd[3:0], ii}] = ref_mem[{lvl, ii}];
          end
          lat = 33;
        end
        default: begin
          for (int i = 0; i < BANK_REGS; i++) begin
            ii = i[3:0];
            ref_mem[{lvl, ii}] = CLEAR_V;
          end
          lat = 17;
        end
      endcase
      exp_q.push_back(e);
      lat_q.push_back(lat);
      acc_q.push_back(acc);
    end
    @(posedge clock);
    #1;
    // Optionally keep presenting the request while busy: it must not be
    // taken a second time.
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready: req_ready=%b while busy (cyc %0d)", bus.req_ready, cyc);
      end
    end
    bus.req_valid = 1'b0;
    // Scramble fields to show the controller latched them.
    bus.req_op    = op_t'($urandom_range(0, 3));
    bus.req_wide  = 1'($urandom_range(0, 1));
    bus.req_level = 4'($urandom);
    bus.req_reg   = 4'($urandom);
    bus.req_wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0 || !bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d responses outstanding, req_ready=%b", exp_q.size(), bus.req_ready);
    end
  endtask

  task automatic check_mem(input logic [7:0] a, input string name);
    checks++;
    if (mem[a] !== ref_mem[a]) begin
      errors++;
      $display("FAIL %s: RAM[%h]=%h expected %h", name, a, mem[a], ref_mem[a]);
    end
  endtask

  task automatic check_val(input logic [31:0] got, input logic [31:0] want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc;
    logic [3:0] ii;
    int op;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_op    = OP_READ;
    bus.req_wide  = 1'b0;
    bus.req_level = 4'h0;
    bus.req_reg   = 4'h0;
    bus.req_wdata = 16'h0000;

    // Reset values
    repeat (3) @(negedge clock);
    check_val(32'(bus.req_ready), 32'd1, "rst_req_ready");
    check_val(32'(bus.rsp_valid), 32'd0, "rst_rsp_valid");
    check_val(32'(bus.rsp_rdata), 32'h0, "rst_rsp_rdata");
    check_val(32'(ram_write_en), 32'd0, "rst_write_en");
    check_val(32'(ram_address), 32'h0, "rst_address");
    check_val(32'(ram_data_in), 32'h0, "rst_data_in");
    reset_n = 1'b1;
    @(negedge clock);
    check_val(32'(bus.req_ready), 32'd1, "post_rst_ready");

    // 1: byte read of level 0 reg 3
    issue(0, 0, 4'd0, 4'd3, 16'h0, 1, 0, acc);
    wait_idle();

    // 2: pair write then pair read
    issue(1, 1, 4'd2, 4'd5, 16'hBEEF, 1, 0, acc);
    wait_idle();
    check_val(32'(mem[8'h24]), 32'hBE, "pair_wr_hi");
    check_val(32'(mem[8'h25]), 32'hEF, "pair_wr_lo");
    issue(0, 1, 4'd2, 4'd4, 16'h0, 1, 0, acc);
    wait_idle();

    // 3: byte write touches only one register
    issue(1, 0, 4'd15, 4'd14, 16'h005A, 1, 0, acc);
    issue(1, 0, 4'd15, 4'd15, 16'h12A5, 1, 0, acc);
    wait_idle();
    check_val(32'(mem[8'hFF]), 32'hA5, "byte_wr");
    check_val(32'(mem[8'hFE]), 32'h5A, "byte_wr_neighbour");
    issue(0, 0, 4'd15, 4'd15, 16'h0, 1, 0, acc);
    wait_idle();

    // 4: bank copy 1 -> 7, then src == dst
    for (int i = 0; i < 16; i++) begin
      ii = i[3:0];
      issue(1, 0, 4'd1, ii, 16'(8'h10 + i), 1, 0, acc);
    end
    issue(2, 0, 4'd1, 4'd0, 16'h0007, 1, 0, acc);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      check_val(32'(mem[8'h70 + i]), 32'(8'h10 + i), "copy_dst");
      check_val(32'(mem[8'h10 + i]), 32'(8'h10 + i), "copy_src");
    end
    issue(2, 0, 4'd1, 4'd0, 16'h0001, 1, 0, acc);
    wait_idle();
    for (int i = 0; i < 16; i++) check_val(32'(mem[8'h10 + i]), 32'(8'h10 + i), "copy_self");

    // 5: bank clear with neighbours populated and req_valid held while busy
    for (int i = 0; i < 16; i++) begin
      ii = i[3:0];
      issue(1, 0, 4'd6, ii, 16'($urandom_range(1, 255)), 1, 0, acc);
      issue(1, 0, 4'd8, ii, 16'($urandom_range(1, 255)), 1, 0, acc);
    end
    issue(3, 0, 4'd7, 4'd0, 16'h0, 1, 16, acc);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      check_val(32'(mem[8'h70 + i]), 32'(CLEAR_V), "clear_bank");
      check_mem(8'(8'h60 + i), "clear_below");
      check_mem(8'(8'h80 + i), "clear_above");
    end

    // 6: reset in C8 of a clear
    for (int i = 0; i < 16; i++) begin
      ii = i[3:0];
      issue(1, 0, 4'd7, ii, 16'(8'hC0 + i), 1, 0, acc);
    end
    wait_idle();
    issue(3, 0, 4'd7, 4'd0, 16'h0, 0, 0, acc);
    while (cyc < acc + 7) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val(32'(ram_write_en), 32'd0, "midrst_write_en");
    check_val(32'(bus.req_ready), 32'd1, "midrst_ready");
    check_val(32'(bus.rsp_valid), 32'd0, "midrst_rsp_valid");
    for (int i = 0; i < 7; i++) ref_mem[8'h70 + i] = CLEAR_V;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 16; i++) check_mem(8'(8'h70 + i), "partial_clear");
    issue(0, 0, 4'd7, 4'd9, 16'h0, 1, 0, acc);
    issue(0, 1, 4'd7, 4'd2, 16'h0, 1, 0, acc);
    wait_idle();

    // Random traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) op = 0;
      else if (op <= 7) op = 1;
      else if (op == 8) op = 2;
      else op = 3;
      issue(op, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
            16'($urandom), 1, 0, acc);
    end
    wait_idle();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 256; i++) check_mem(8'(i), "final_sweep");
    check_val(32'(exp_q.size()), 32'd0, "leftover_expected");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
